// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared constants and state encoding for the ADC capture stage.
`default_nettype none

package adc_cap_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;
  localparam int ADDR_W_DEF = 8;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    READOUT   = 2'd3
  } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/adc_cap_ram.sv
// adc_cap_ram: simple dual-port frame buffer, one write port, one registered read port.
`default_nettype none

module adc_cap_ram
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/adc_capture.sv
// adc_capture: decimated, triggered single-frame ADC capture with valid/ready readout
// and per-frame min/max statistics.
`default_nettype none

module adc_capture
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ad_in,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [DIV_W-1:0]  div,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [DATA_W-1:0] pk_max,
  output logic [DATA_W-1:0] pk_min
);

  localparam logic [ADDR_W-1:0] LAST_WADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_RADDR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   N_WORDS    = (ADDR_W + 1)'(DEPTH);

  cap_state_t state, state_nx;

  logic [DATA_W-1:0] s_cur, s_prev;
  logic              have_prev;
  logic [DIV_W-1:0]  div_q, div_cnt;
  logic              strobe, arm_ok, crossing, trig;

  logic [ADDR_W-1:0] wptr, waddr;
  logic              we;

  logic [ADDR_W:0]   raddr_cnt;
  logic              re, rd_rem;
  logic [DATA_W-1:0] ram_q;
  logic              pend, pend_last;
  logic              sk_v, sk_last;
  logic [DATA_W-1:0] sk_data;
  logic              out_free, hs, last_hs;

  assign busy     = (state != IDLE);
  assign arm_ok   = (state == IDLE) && arm;
  assign strobe   = (div_cnt == div_q);
  assign crossing = trig_edge ? ((s_prev > trig_level) && (s_cur <= trig_level))
                              : ((s_prev < trig_level) && (s_cur >= trig_level));
  assign trig     = (state == WAIT_TRIG) && (force_trig || (strobe && have_prev && crossing));

  assign hs       = rd_valid && rd_ready;
  assign last_hs  = hs && rd_last;
  assign out_free = !rd_valid || rd_ready;
  assign rd_rem   = (state == READOUT) && (raddr_cnt != N_WORDS);
  // A read is issued only when its data is guaranteed a home (output or skid) next cycle.
  assign re       = rd_rem && (out_free || (!sk_v && !pend));

  always_comb begin
    state_nx = state;
    we       = 1'b0;
    waddr    = wptr;
    case (state)
      IDLE:      if (arm) state_nx = WAIT_TRIG;
      WAIT_TRIG: if (trig) begin
        we       = 1'b1;
        waddr    = '0;
        state_nx = CAPTURE;
      end
      CAPTURE:   if (strobe) begin
        we = 1'b1;
        if (wptr == LAST_WADDR) state_nx = READOUT;
      end
      READOUT:   if (last_hs) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Input register, decimation strobe and previous-strobe sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cur     <= '0;
      s_prev    <= '0;
      have_prev <= 1'b0;
      div_q     <= '0;
      div_cnt   <= '0;
    end else begin
      s_cur <= ad_in;
      if (arm_ok) begin
        div_q     <= div;
        div_cnt   <= '0;
        have_prev <= 1'b0;
      end else begin
        div_cnt <= strobe ? '0 : div_cnt + DIV_W'(1);
        if (strobe) begin
          s_prev    <= s_cur;
          have_prev <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      pk_max <= '0;
      pk_min <= '1;
    end else if (trig) begin
      wptr   <= ADDR_W'(1);
      pk_max <= s_cur;
      pk_min <= s_cur;
    end else if ((state == CAPTURE) && strobe) begin
      wptr <= wptr + ADDR_W'(1);
      if (s_cur > pk_max) pk_max <= s_cur;
      if (s_cur < pk_min) pk_min <= s_cur;
    end
  end

  adc_cap_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (s_cur),
    .re    (re),
    .raddr (raddr_cnt[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  // Readout: RAM output lands in the output register, or in the skid register when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_cnt <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      sk_v      <= 1'b0;
      sk_data   <= '0;
      sk_last   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_hs;
      if (state != READOUT) raddr_cnt <= '0;
      else if (re)          raddr_cnt <= raddr_cnt + (ADDR_W + 1)'(1);
      pend <= re;
      if (re) pend_last <= (raddr_cnt == LAST_RADDR);

      if (out_free) begin
        if (sk_v) begin
          rd_valid <= 1'b1;
          rd_data  <= sk_data;
          rd_last  <= sk_last;
        end else if (pend) begin
          rd_valid <= 1'b1;
          rd_data  <= ram_q;
          rd_last  <= pend_last;
        end else begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end

      if (pend && (!out_free || sk_v)) begin
        sk_v    <= 1'b1;
        sk_data <= ram_q;
        sk_last <= pend_last;
      end else if (out_free) begin
        sk_v <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed + randomized checks of adc_capture against a trace-based frame model.
`timescale 1ns/1ps
`default_nettype none

module tb_adc_capture;
  import adc_cap_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int AW    = ADDR_W_DEF;
  localparam int DIVW  = DIV_W_DEF;
  localparam int HIST  = 32768;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   ad_in = '0;
  logic            arm = 1'b0;
  logic            force_trig = 1'b0;
  logic [DW-1:0]   trig_level = '0;
  logic            trig_edge = 1'b0;
  logic [DIVW-1:0] div = '0;
  logic            busy, done, rd_valid, rd_last;
  logic            rd_ready = 1'b0;
  logic [DW-1:0]   rd_data, pk_max, pk_min;

  always #5 clk = ~clk;

  adc_capture #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .DIV_W(DIVW)) dut (
    .clk(clk), .rst_n(rst_n), .ad_in(ad_in), .arm(arm), .force_trig(force_trig),
    .trig_level(trig_level), .trig_edge(trig_edge), .div(div), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .pk_max(pk_max), .pk_min(pk_min)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int ecount   = 0;
  int pat      = 0;   // 0: ramp +1/cycle, 1: hold, 2: random
  logic [DW-1:0] samp [HIST];
  logic          frc  [HIST];
  logic [DW-1:0] exp_frame [DEPTH];
  logic [DW-1:0] got [$];
  logic          lasts [$];

  // Trace of what the DUT sampled at each rising edge.
  always @(posedge clk) begin
    if (ecount < HIST) begin
      samp[ecount] <= ad_in;
      frc[ecount]  <= force_trig;
    end
    ecount <= ecount + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (pat)
      0:       ad_in = ad_in + 8'd1;
      2:       ad_in = 8'($urandom);
      default: ;
    endcase
  endtask

  task automatic do_arm(input logic [DIVW-1:0] d, output int ae);
    check("busy_before_arm", 32'(busy), 32'd0);
    div = d;
    arm = 1'b1;
    ae  = ecount;
    step();
    arm = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  // Frame model: walks the sampled trace from the arm edge, applying the trigger and
  // decimation rules directly; returns how many frame words it could determine.
  function automatic int model(input int ae, input int d, input logic [DW-1:0] lvl, input bit fall);
    int n;
    bit trg, have, stb;
    logic [DW-1:0] prev, cur;
    n = 0; trg = 0; have = 0; prev = '0;
    for (int e = ae + 1; e < ecount && e < HIST && n < DEPTH; e++) begin
      stb = (((e - ae - 1) % (d + 1)) == d);
      cur = samp[e-1];
      if (!trg) begin
        if (frc[e]) trg = 1;
        else if (stb) begin
          if (have && (fall ? (prev > lvl && cur <= lvl) : (prev < lvl && cur >= lvl))) trg = 1;
          prev = cur;
          have = 1;
        end
        if (trg) begin exp_frame[n] = cur; n++; end
      end else if (stb) begin
        exp_frame[n] = cur;
        n++;
      end
    end
    return n;
  endfunction

  task automatic run_frame(input bit rnd);
    bit stall;
    logic [DW-1:0] sd;
    logic sl;
    int ndone, extra;
    stall = 0; sd = '0; sl = 0; ndone = 0; extra = 0;
    got.delete();
    lasts.delete();
    for (int c = 0; c < 8000 && extra < 4; c++) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stall) begin
        check("stall_valid", 32'(rd_valid), 32'd1);
        check("stall_data", 32'(rd_data), 32'(sd));
        check("stall_last", 32'(rd_last), 32'(sl));
      end
      if (!rnd && got.size() > 0 && got.size() < DEPTH) check("no_bubble", 32'(rd_valid), 32'd1);
      if (done) ndone++;
      if (rd_valid && rd_ready) begin
        got.push_back(rd_data);
        lasts.push_back(rd_last);
      end
      stall = rd_valid && !rd_ready;
      sd = rd_data;
      sl = rd_last;
      if (got.size() >= DEPTH) extra++;
      step();
    end
    rd_ready = 1'b0;
    check("word_count", 32'(got.size()), 32'(DEPTH));
    check("done_pulses", 32'(ndone), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string nm, input int ae, input int d,
                             input logic [DW-1:0] lvl, input bit fall);
    int n;
    logic [DW-1:0] mx, mn;
    mx = '0; mn = '1;
    n = model(ae, d, lvl, fall);
    for (int i = 0; i < n; i++) begin
      if (exp_frame[i] > mx) mx = exp_frame[i];
      if (exp_frame[i] < mn) mn = exp_frame[i];
      if (i < got.size()) begin
        check($sformatf("%s_data%0d", nm, i), 32'(got[i]), 32'(exp_frame[i]));
        check($sformatf("%s_last%0d", nm, i), 32'(lasts[i]), 32'(i == DEPTH - 1));
      end
    end
    check({nm, "_pk_max"}, 32'(pk_max), 32'(mx));
    check({nm, "_pk_min"}, 32'(pk_min), 32'(mn));
  endtask

  initial begin
    int ae, d;
    logic [DW-1:0] lvl;
    bit fall;

    // Reset values
    pat = 1;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_pk_max", 32'(pk_max), 32'h00);
    check("rst_pk_min", 32'(pk_min), 32'hFF);
    rst_n = 1'b1;
    repeat (2) step();

    // Rising trigger on a ramp
    pat = 0; ad_in = 8'h00; trig_level = 8'h80; trig_edge = 1'b0;
    step();
    do_arm(8'd0, ae);
    run_frame(1'b0);
    check("rise_word0", 32'(got[0]), 32'h80);
    check("rise_word255", 32'(got[DEPTH-1]), 32'h7F);
    check_frame("rise", ae, 0, 8'h80, 1'b0);

    // Decimation by 4 with an immediate forced trigger
    do_arm(8'd3, ae);
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
    run_frame(1'b0);
    for (int i = 1; i < DEPTH - 1; i++) check("dec_step", 32'(8'(got[i+1] - got[i])), 32'd4);
    check_frame("dec", ae, 3, 8'h80, 1'b0);

    // Falling trigger; a crossing before arm must not count
    pat = 1; trig_level = 8'h80; trig_edge = 1'b1;
    ad_in = 8'hFF; step(); ad_in = 8'h10; step(); ad_in = 8'hFF;
    repeat (3) step();
    do_arm(8'd0, ae);
    repeat (20) step();
    check("fall_wait_busy", 32'(busy), 32'd1);
    check("fall_wait_valid", 32'(rd_valid), 32'd0);
    ad_in = 8'h10;
    run_frame(1'b0);
    check("fall_word0", 32'(got[0]), 32'h10);
    check_frame("fall", ae, 0, 8'h80, 1'b1);

    // Forced capture of a constant; arm during CAPTURE is ignored
    ad_in = 8'h55; trig_edge = 1'b0;
    step();
    d = int'($urandom_range(0, 2));
    do_arm(DIVW'(d), ae);
    force_trig = 1'b1; step(); force_trig = 1'b0;
    repeat (10) step();
    div = 8'd7; arm = 1'b1; step(); arm = 1'b0;
    run_frame(1'b0);
    repeat (3) step();
    check("arm_ignored_idle", 32'(busy), 32'd0);
    check("const_pk_max", 32'(pk_max), 32'h55);
    check("const_pk_min", 32'(pk_min), 32'h55);
    check_frame("const", ae, d, 8'h80, 1'b0);

    // Random data, decimation, trigger settings and backpressure
    pat = 2;
    for (int it = 0; it < 2; it++) begin
      d = int'($urandom_range(0, 3));
      lvl = 8'($urandom);
      fall = 1'($urandom_range(0, 1));
      trig_level = lvl; trig_edge = fall;
      do_arm(DIVW'(d), ae);
      repeat ($urandom_range(3, 30)) step();
      force_trig = 1'b1; step(); force_trig = 1'b0;
      run_frame(1'b1);
      check_frame("bp", ae, d, lvl, fall);
    end

    // Reset while capturing at write pointer 100
    pat = 0; trig_level = 8'h80; trig_edge = 1'b0;
    do_arm(8'd0, ae);
    force_trig = 1'b1; step(); force_trig = 1'b0;
    repeat (99) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_pk_min", 32'(pk_min), 32'hFF);
    step();
    rst_n = 1'b1;
    step();
    do_arm(8'd0, ae);
    force_trig = 1'b1; step(); force_trig = 1'b0;
    run_frame(1'b0);
    check_frame("post_rst", ae, 0, 8'h80, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
